// File: rtl/mkt_pkg.sv
// Shared constants, message layout and header-stage state type for the
// receive-side market-data pipeline.
package mkt_pkg;

  localparam int unsigned HDR_BYTES_DEF = 14;
  localparam int unsigned MSG_BYTES     = 17;
  localparam int unsigned IDX_W         = 5;

  localparam logic [7:0] MSG_ADD  = 8'h41;
  localparam logic [7:0] DEC_BUY  = 8'h42;
  localparam logic [7:0] DEC_SELL = 8'h53;

  // Big-endian wire order: msg_type is the first byte received
  typedef struct packed {
    logic [7:0]  msg_type;
    logic [63:0] order_id;
    logic [31:0] price;
    logic [31:0] volume;
  } order_msg_t;

  typedef enum logic {
    HDR = 1'b0,
    PAY = 1'b1
  } rx_state_t;

endpackage

// File: rtl/mkt_msg_deframer.sv
// Splits the payload byte stream into fixed 17-byte order messages and
// presents each completed message with a one-cycle field_valid.
module mkt_msg_deframer
  import mkt_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] pay_byte,
  input  logic       pay_valid,
  output order_msg_t fields,
  output logic       field_valid
);

  localparam int unsigned SHIFT_W = (MSG_BYTES - 1) * 8;

  logic [IDX_W-1:0]   idx;
  logic [SHIFT_W-1:0] shreg;

  // A low pay_valid only occurs at a frame boundary, so it also drops partials
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= '0;
      shreg       <= '0;
      fields      <= '0;
      field_valid <= 1'b0;
    end else begin
      field_valid <= 1'b0;
      if (pay_valid) begin
        shreg <= {shreg[SHIFT_W-9:0], pay_byte};
        if (idx == IDX_W'(MSG_BYTES - 1)) begin
          fields      <= order_msg_t'({shreg, pay_byte});
          field_valid <= 1'b1;
          idx         <= '0;
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end else begin
        idx <= '0;
      end
    end
  end

endmodule

// File: rtl/market_rx_pipeline.sv
// Ethernet byte stream in, registered buy/sell decisions out: strips the L2
// header, deframes order messages and applies the price thresholds.
module market_rx_pipeline
  import mkt_pkg::*;
#(
  parameter int unsigned HDR_BYTES      = HDR_BYTES_DEF,
  parameter logic [31:0] BUY_THRESHOLD  = 32'd1000,
  parameter logic [31:0] SELL_THRESHOLD = 32'd2000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic        decision_valid,
  output logic [7:0]  decision_type,
  output logic [63:0] d_order_id,
  output logic [31:0] d_price,
  output logic [31:0] d_volume
);

  localparam int unsigned CNT_W = $clog2(HDR_BYTES + 1);

  rx_state_t        state;
  logic [CNT_W-1:0] hdr_cnt;
  logic [7:0]       pay_byte;
  logic             pay_valid;
  order_msg_t       fields;
  logic             field_valid;
  logic             buy_c;
  logic             sell_c;

  // Header strip: discard HDR_BYTES, then forward payload one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HDR;
      hdr_cnt   <= '0;
      pay_byte  <= '0;
      pay_valid <= 1'b0;
    end else begin
      pay_valid <= 1'b0;
      if (!rx_valid) begin
        state   <= HDR;
        hdr_cnt <= '0;
      end else begin
        case (state)
          HDR: begin
            if (hdr_cnt == CNT_W'(HDR_BYTES - 1)) begin
              state   <= PAY;
              hdr_cnt <= '0;
            end else begin
              hdr_cnt <= hdr_cnt + CNT_W'(1);
            end
          end
          PAY: begin
            pay_valid <= 1'b1;
            pay_byte  <= rx_byte;
          end
          default: state <= HDR;
        endcase
      end
    end
  end

  mkt_msg_deframer u_deframer (
    .clk         (clk),
    .rst_n       (rst_n),
    .pay_byte    (pay_byte),
    .pay_valid   (pay_valid),
    .fields      (fields),
    .field_valid (field_valid)
  );

  // Buy wins if misconfigured thresholds would let both fire
  assign buy_c  = field_valid && (fields.msg_type == MSG_ADD) && (fields.price < BUY_THRESHOLD);
  assign sell_c = field_valid && (fields.msg_type == MSG_ADD) && (fields.price > SELL_THRESHOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      decision_valid <= 1'b0;
      decision_type  <= '0;
      d_order_id     <= '0;
      d_price        <= '0;
      d_volume       <= '0;
    end else begin
      decision_valid <= buy_c || sell_c;
      if (buy_c || sell_c) begin
        decision_type <= buy_c ? DEC_BUY : DEC_SELL;
        d_order_id    <= fields.order_id;
        d_price       <= fields.price;
        d_volume      <= fields.volume;
      end
    end
  end

endmodule

// File: tb/tb_market_rx_pipeline.sv
// Self-checking bench: frames built from order messages, decisions predicted
// per message from the price rules and matched against observed pulses.
module tb_market_rx_pipeline;

  localparam int unsigned HDR = 14;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_valid = 1'b0;
  logic        decision_valid;
  logic [7:0]  decision_type;
  logic [63:0] d_order_id;
  logic [31:0] d_price;
  logic [31:0] d_volume;

  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  t;
    logic [63:0] id;
    logic [31:0] p;
    logic [31:0] v;
  } dec_t;

  dec_t        exp_q[$];
  dec_t        got_q[$];
  dec_t        mon_d;
  logic [7:0]  pay_q[$];
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  market_rx_pipeline #(
    .HDR_BYTES      (HDR),
    .BUY_THRESHOLD  (32'd1000),
    .SELL_THRESHOLD (32'd2000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx_byte        (rx_byte),
    .rx_valid       (rx_valid),
    .decision_valid (decision_valid),
    .decision_type  (decision_type),
    .d_order_id     (d_order_id),
    .d_price        (d_price),
    .d_volume       (d_volume)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && decision_valid) begin
      mon_d.cyc = cyc;
      mon_d.t   = decision_type;
      mon_d.id  = d_order_id;
      mon_d.p   = d_price;
      mon_d.v   = d_volume;
      got_q.push_back(mon_d);
    end
  end

  task automatic push_msg(input logic [7:0] t, input logic [63:0] id,
                          input logic [31:0] p, input logic [31:0] v);
    pay_q.push_back(t);
    for (int i = 7; i >= 0; i--) pay_q.push_back(id[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) pay_q.push_back(p[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) pay_q.push_back(v[i*8 +: 8]);
  endtask

  // Drives random header + pay_q, predicting one decision per complete message
  task automatic send_frame();
    dec_t        d;
    int unsigned e;
    for (int i = 0; i < int'(HDR); i++) begin
      @(negedge clk); rx_valid = 1'b1; rx_byte = 8'($urandom);
    end
    for (int k = 0; k < pay_q.size(); k++) begin
      @(negedge clk); rx_valid = 1'b1; rx_byte = pay_q[k];
      e = cyc + 1;
      if (k % 17 == 16) begin
        d.cyc = e + 2;
        d.t   = pay_q[k-16];
        d.id  = '0;
        d.p   = '0;
        d.v   = '0;
        for (int j = 1; j <= 8; j++)  d.id = {d.id[55:0], pay_q[k-16+j]};
        for (int j = 9; j <= 12; j++) d.p  = {d.p[23:0], pay_q[k-16+j]};
        for (int j = 13; j <= 16; j++) d.v = {d.v[23:0], pay_q[k-16+j]};
        if (d.t == 8'h41 && d.p < 32'd1000) begin
          d.t = 8'h42; exp_q.push_back(d);
        end else if (d.t == 8'h41 && d.p > 32'd2000) begin
          d.t = 8'h53; exp_q.push_back(d);
        end
      end
    end
    @(negedge clk); rx_valid = 1'b0; rx_byte = 8'h00;
    repeat (4) @(negedge clk);
    pay_q.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({decision_valid, decision_type, d_order_id, d_price, d_volume} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got valid=%b type=%h id=%h price=%h vol=%h, expected all zero",
               decision_valid, decision_type, d_order_id, d_price, d_volume);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_buy();
    exp_q.delete(); got_q.delete();
    push_msg(8'h41, 64'h0102030405060708, 32'd500, 32'd10);
    send_frame();
    n_cmp++;
    if (got_q.size() != exp_q.size() || got_q.size() != 1) begin
      n_err++; $display("FAIL buy_count: got %0d pulses, expected 1", got_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL buy_pulse[%0d]: got cyc=%0d type=%h price=%0d, expected cyc=%0d type=%h price=%0d",
                 i, got_q[i].cyc, got_q[i].t, got_q[i].p, exp_q[i].cyc, exp_q[i].t, exp_q[i].p);
      end
    end
    n_cmp++;
    if ({decision_type, d_order_id, d_price, d_volume} !== {8'h42, 64'h0102030405060708, 32'd500, 32'd10}) begin
      n_err++;
      $display("FAIL buy_fields: got type=%h id=%h price=%0d vol=%0d, expected 42 0102030405060708 500 10",
               decision_type, d_order_id, d_price, d_volume);
    end
  endtask

  task automatic test_sell_and_none();
    exp_q.delete(); got_q.delete();
    push_msg(8'h41, 64'h0102030405060708, 32'd2500, 32'd10);
    send_frame();
    n_cmp++;
    if (got_q.size() != 1) begin
      n_err++; $display("FAIL sell_count: got %0d pulses, expected 1", got_q.size());
    end else if (got_q[0] !== exp_q[0] || got_q[0].t !== 8'h53 || got_q[0].p !== 32'd2500) begin
      n_err++;
      $display("FAIL sell_pulse: got cyc=%0d type=%h price=%0d, expected cyc=%0d type=53 price=2500",
               got_q[0].cyc, got_q[0].t, got_q[0].p, exp_q[0].cyc);
    end
    got_q.delete();
    push_msg(8'h41, 64'h1111, 32'd1000, 32'd1);
    send_frame();
    push_msg(8'h41, 64'h2222, 32'd1500, 32'd2);
    send_frame();
    push_msg(8'h41, 64'h3333, 32'd2000, 32'd3);
    send_frame();
    n_cmp++;
    if (got_q.size() != 0) begin
      n_err++; $display("FAIL no_decision_band: got %0d pulses, expected 0", got_q.size());
    end
    n_cmp++;
    if ({decision_type, d_price, d_volume} !== {8'h53, 32'd2500, 32'd10}) begin
      n_err++;
      $display("FAIL hold_outputs: got type=%h price=%0d vol=%0d, expected 53 2500 10",
               decision_type, d_price, d_volume);
    end
  endtask

  task automatic test_other_type();
    got_q.delete();
    push_msg(8'h58, 64'h4444, 32'd500, 32'd4);
    send_frame();
    n_cmp++;
    if (got_q.size() != 0 || d_price !== 32'd2500) begin
      n_err++;
      $display("FAIL other_type: got %0d pulses price=%0d, expected 0 pulses price=2500",
               got_q.size(), d_price);
    end
  endtask

  task automatic test_back_to_back();
    exp_q.delete(); got_q.delete();
    push_msg(8'h41, 64'hAAAA_0000_0000_0001, 32'd100, 32'd7);
    push_msg(8'h41, 64'hBBBB_0000_0000_0002, 32'd3000, 32'd8);
    send_frame();
    n_cmp++;
    if (got_q.size() != 2) begin
      n_err++; $display("FAIL b2b_count: got %0d pulses, expected 2", got_q.size());
    end else begin
      n_cmp++;
      if (got_q[1].cyc - got_q[0].cyc !== 32'd17) begin
        n_err++; $display("FAIL b2b_spacing: got %0d cycles, expected 17", got_q[1].cyc - got_q[0].cyc);
      end
      n_cmp++;
      if (got_q[0].t !== 8'h42 || got_q[1] !== {exp_q[0].cyc + 32'd17, 8'h53, 64'hBBBB_0000_0000_0002, 32'd3000, 32'd8}) begin
        n_err++;
        $display("FAIL b2b_fields: got %h/%h id=%h price=%0d vol=%0d, expected 42/53 id=bbbb000000000002 price=3000 vol=8",
                 got_q[0].t, got_q[1].t, got_q[1].id, got_q[1].p, got_q[1].v);
      end
    end
  endtask

  task automatic test_partial();
    exp_q.delete(); got_q.delete();
    push_msg(8'h41, 64'h5555, 32'd10, 32'd5);
    while (pay_q.size() > 10) void'(pay_q.pop_back());
    send_frame();
    push_msg(8'h41, 64'h6666_7777_8888_9999, 32'd700, 32'd6);
    send_frame();
    n_cmp++;
    if (got_q.size() != 1) begin
      n_err++; $display("FAIL partial_count: got %0d pulses, expected 1", got_q.size());
    end else if (got_q[0] !== exp_q[0] || got_q[0].p !== 32'd700) begin
      n_err++;
      $display("FAIL partial_next: got cyc=%0d type=%h price=%0d, expected cyc=%0d type=42 price=700",
               got_q[0].cyc, got_q[0].t, got_q[0].p, exp_q[0].cyc);
    end
  endtask

  task automatic test_async_reset();
    exp_q.delete(); got_q.delete();
    push_msg(8'h41, 64'hDEAD, 32'd20, 32'd9);
    for (int i = 0; i < int'(HDR); i++) begin
      @(negedge clk); rx_valid = 1'b1; rx_byte = 8'h00;
    end
    for (int k = 0; k < 9; k++) begin
      @(negedge clk); rx_byte = pay_q[k];
    end
    pay_q.delete();
    @(posedge clk); #2 rst_n = 1'b0; #1;
    n_cmp++;
    if ({decision_valid, decision_type, d_order_id, d_price, d_volume} !== '0) begin
      n_err++;
      $display("FAIL async_reset: got type=%h id=%h price=%0d vol=%0d, expected all zero",
               decision_type, d_order_id, d_price, d_volume);
    end
    repeat (3) begin
      @(negedge clk); rx_byte = 8'h41;
    end
    @(posedge clk); #1 rst_n = 1'b1;
    push_msg(8'h41, 64'hCAFE_F00D_0000_0001, 32'd5000, 32'd11);
    send_frame();
    n_cmp++;
    if (got_q.size() != 1) begin
      n_err++; $display("FAIL post_reset_count: got %0d pulses, expected 1", got_q.size());
    end else if (got_q[0] !== exp_q[0] || got_q[0].t !== 8'h53) begin
      n_err++;
      $display("FAIL post_reset_pulse: got cyc=%0d type=%h price=%0d, expected cyc=%0d type=53 price=5000",
               got_q[0].cyc, got_q[0].t, got_q[0].p, exp_q[0].cyc);
    end
  endtask

  task automatic test_random();
    logic [7:0]  t;
    logic [31:0] p;
    exp_q.delete(); got_q.delete();
    for (int f = 0; f < 25; f++) begin
      for (int m = 0; m < int'($urandom_range(0, 3)); m++) begin
        t = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h41;
        case ($urandom_range(0, 7))
          0: p = 32'd999;
          1: p = 32'd1000;
          2: p = 32'd1001;
          3: p = 32'd1999;
          4: p = 32'd2000;
          5: p = 32'd2001;
          6: p = $urandom_range(0, 3000);
          default: p = $urandom;
        endcase
        push_msg(t, {$urandom, $urandom}, p, $urandom);
      end
      for (int b = 0; b < int'($urandom_range(0, 16)); b++) pay_q.push_back(8'($urandom));
      send_frame();
    end
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL random_count: got %0d pulses, expected %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL random_pulse[%0d]: got cyc=%0d type=%h id=%h price=%0d vol=%0d, expected cyc=%0d type=%h id=%h price=%0d vol=%0d",
                 i, got_q[i].cyc, got_q[i].t, got_q[i].id, got_q[i].p, got_q[i].v,
                 exp_q[i].cyc, exp_q[i].t, exp_q[i].id, exp_q[i].p, exp_q[i].v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_buy();
    test_sell_and_none();
    test_other_type();
    test_back_to_back();
    test_partial();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
